// File: rtl/cpu_pkg.sv
// Shared encodings for the RSA 5-stage pipeline: Id type/op fields, forwarding
// selects and the hazard unit's MUL occupancy states.
package cpu_pkg;
  localparam logic [1:0] TYPE_SYS  = 2'b00;
  localparam logic [1:0] TYPE_DP   = 2'b01;
  localparam logic [1:0] TYPE_MEM  = 2'b10;
  localparam logic [1:0] TYPE_CTRL = 2'b11;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } hz_state_t;

  function automatic logic is_mul(input logic [6:0] id);
    return (id[6:5] == TYPE_DP) && (id[4:2] == OP_MUL);
  endfunction
endpackage

// File: rtl/mul_occupancy_fsm.sv
// Holds a MUL in the execute stage for MUL_LATENCY cycles; mul_busy while it
// must stay, mul_done in its last cycle.
module mul_occupancy_fsm #(
  parameter int MUL_LATENCY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mul_e,
  output logic mul_busy,
  output logic mul_done
);
  import cpu_pkg::*;

  localparam int            CW       = $clog2(MUL_LATENCY) + 1;
  localparam logic          MULTI    = (MUL_LATENCY > 1);
  localparam logic [CW-1:0] CNT_INIT = CW'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

  hz_state_t     state;
  logic [CW-1:0] cnt;

  // mul_e is deliberately ignored in MUL_WAIT: the held MUL must not restart itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_e && MULTI) begin
            state <= MUL_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        MUL_WAIT: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mul_busy = ((state == IDLE) && mul_e && MULTI) ||
               ((state == MUL_WAIT) && (cnt != '0));
    mul_done = ((state == MUL_WAIT) && (cnt == '0)) ||
               (!MULTI && mul_e);
  end
endmodule

// File: rtl/hazard_sched_unit.sv
// Hazard controller for the F/D/E/M/W pipeline: MUL occupancy, load-use stall,
// taken-branch flush and E operand forwarding. HAZARD_PERF_CNT_EN adds counters.
module hazard_sched_unit #(
  parameter int REG_AW      = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        id_e,
  input  logic [REG_AW-1:0] ra_d,
  input  logic [REG_AW-1:0] rb_d,
  input  logic              uses_ra_d,
  input  logic              uses_rb_d,
  input  logic [REG_AW-1:0] ra_e,
  input  logic [REG_AW-1:0] rb_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              regwrite_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_w,
  input  logic              branch_taken_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              mul_busy,
  output logic              mul_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);
  import cpu_pkg::*;

  logic     busy, done, load_use;
  fwd_sel_t fwd_a, fwd_b;

  mul_occupancy_fsm #(.MUL_LATENCY(MUL_LATENCY)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .mul_e    (is_mul(id_e)),
    .mul_busy (busy),
    .mul_done (done)
  );

  assign load_use = regwrite_e && memtoreg_e &&
                    ((uses_ra_d && (ra_d == rd_e)) || (uses_rb_d && (rb_d == rd_e)));

  // No hard-wired zero register, so r0 matches forward like any other.
  always_comb begin
    fwd_a = FWD_RF;
    if (regwrite_m && (rd_m == ra_e))      fwd_a = FWD_M;
    else if (regwrite_w && (rd_w == ra_e)) fwd_a = FWD_W;
    fwd_b = FWD_RF;
    if (regwrite_m && (rd_m == rb_e))      fwd_b = FWD_M;
    else if (regwrite_w && (rd_w == rb_e)) fwd_b = FWD_W;
  end

  // Everything is forced low while reset is held, including the combinational paths.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    mul_busy = 1'b0;
    mul_done = 1'b0;
    fwd_a_e  = FWD_RF;
    fwd_b_e  = FWD_RF;
    if (rst_n) begin
      fwd_a_e = fwd_a;
      fwd_b_e = fwd_b;
      if (busy) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        flush_m  = 1'b1;
        mul_busy = 1'b1;
      end else begin
        mul_done = done;
        if (branch_taken_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_f)             stall_cycles <= stall_cycles + 32'd1;
      if (flush_d || flush_e)  flush_events <= flush_events + 32'd1;
    end
  end
`endif
endmodule

// File: doc/hazard_sched_unit.md
Name: hazard_sched_unit

Overview:
- Pipeline hazard controller and scheduler for the 5-stage RSA pipeline CPU (F/D/E/M/W).
- Sequences multi-cycle MUL occupancy of the execute-stage ALU, detects load-use hazards, flushes on taken control-flow, and selects forwarding sources for E operands.
- Uses the 7-bit Id encoding: Id[6:5] type (00 sys, 01 DP, 10 MEM, 11 ctrl), Id[4] STR/LDR, Id[4:2] DP op (011 MUL).

Parameters:
- REG_AW, 4, register-address width.
- MUL_LATENCY, 3, total cycles a MUL occupies E; legal range ≥1. A value of 1 means MUL is single-cycle and never stalls.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_e  in  7  Id of the instruction in E; 0 when E holds a bubble.
- ra_d, rb_d  in  REG_AW each  source registers of the D instruction.
- uses_ra_d, uses_rb_d  in  1 each  D instruction actually reads ra_d or rb_d.
- ra_e, rb_e  in  REG_AW each  source registers of the E instruction.
- rd_e  in  REG_AW  destination register of the E instruction.
- regwrite_e, memtoreg_e  in  1 each  E-stage control bits.
- rd_m, regwrite_m  in  REG_AW, 1  M-stage destination register and write enable.
- rd_w, regwrite_w  in  REG_AW, 1  W-stage destination register and write enable.
- branch_taken_e  in  1  control instruction in E resolved taken.
- stall_f, stall_d, stall_e  out  1 each  hold the PC, the F/D register, and the D/E register.
- flush_d, flush_e, flush_m  out  1 each  insert a bubble into F/D, D/E, and E/M.
- fwd_a_e, fwd_b_e  out  2 each  operand source: 00 register file, 10 from M, 01 from W.
- mul_busy  out  1  a MUL is stalling E.
- mul_done  out  1  one-cycle pulse in the final MUL cycle.

Behaviour:
- Reset: FSM goes to IDLE and cnt to 0. All outputs are 0 while rst_n is low. Reset asserted mid-MUL aborts the sequence; after release the unit is in IDLE.
- mul_e = (id_e[6:5]==01 && id_e[4:2]==011).
- FSM states: IDLE and MUL_WAIT. Down-counter cnt is $clog2(MUL_LATENCY)+1 bits wide.
- IDLE, mul_e=1, MUL_LATENCY>1: mul_busy=1; cnt<=MUL_LATENCY-2; next state MUL_WAIT.
- MUL_WAIT, cnt≠0: mul_busy=1; cnt decrements each cycle.
- MUL_WAIT, cnt=0: mul_busy=0; mul_done=1; next state IDLE.
- mul_e is ignored in MUL_WAIT, so the held MUL is never restarted. A back-to-back MUL seen in IDLE on the next cycle starts a new sequence.
- MUL_LATENCY=1: FSM never leaves IDLE. mul_done pulses in the same cycle whenever mul_e=1.
- Net MUL cost is MUL_LATENCY-1 stall cycles.
- Priority 1, mul_busy: stall_f = stall_d = stall_e = 1, flush_m = 1; all other outputs 0.
- Priority 2, branch_taken_e: flush_d = flush_e = 1; no stall. This overrides a simultaneous load-use.
- Priority 3, load-use: condition is regwrite_e && memtoreg_e && ((uses_ra_d && ra_d==rd_e) || (uses_rb_d && rb_d==rd_e)). Response: stall_f = stall_d = 1, flush_e = 1, for exactly one cycle.
- Forwarding (combinational, independent of priority):
  - fwd_a_e = 10 if regwrite_m && rd_m==ra_e.
  - Otherwise 01 if regwrite_w && rd_w==ra_e.
  - Otherwise 00.
  - M has priority over W. fwd_b_e uses rb_e with the same rule.
- There is no hard-wired zero register, so every match forwards.
- All hazard outputs are combinational from inputs and state. Zero-cycle latency.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments every cycle stall_f=1.
  - flush_events increments every cycle flush_d|flush_e=1.
  - Both wrap at 2^32 and reset to 0.
- HAZARD_PERF_CNT_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - Type codes TYPE_SYS/DP/MEM/CTRL.
  - DP op codes OP_ADD/SUB/MOV/MUL/CMP.
  - fwd_sel_t enum (FWD_RF=00, FWD_W=01, FWD_M=10).
  - hz_state_t enum (IDLE, MUL_WAIT).
- Natural sub-module: mul_occupancy_fsm, containing the FSM, cnt, mul_busy and mul_done.

Test Plan:
- MUL_LATENCY=3, MUL enters E at cycle t → mul_busy=1 at t and t+1; stall_f/d/e and flush_m=1 at t and t+1; mul_done=1 at t+2 only.
- Back-to-back MULs in E → second MUL starts a new sequence at t+3 (stalls at t+3 and t+4), not at t+2.
- LDR r3 in E (regwrite_e=1, memtoreg_e=1, rd_e=3), D reads r3 → stall_f=stall_d=flush_e=1 for one cycle. Same case with uses_ra_d=uses_rb_d=0 → no stall.
- branch_taken_e=1 together with a load-use condition → flush_d=flush_e=1, stall_f=0.
- rd_m=rd_w=5, both writing, ra_e=5 → fwd_a_e=10. Drop regwrite_m → fwd_a_e=01.
- Assert rst_n=0 during MUL_WAIT cnt=1 → all outputs 0 immediately. After release: IDLE, and a new MUL gives the full 2-cycle stall.
